// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Holds the miss FSM encoding, the refill timeout default and the register-zero constant.
package pipeline_stall_ctrl_pkg;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int REG_W           = 5;
  localparam int STALL_CNT_W     = 16;
  localparam int WAIT_CNT_W      = 8;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MISS   = 2'd1,
    ST_REPLAY = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Pipeline-side signal bundle for the stall controller.
// The pipeline uses the master modport; the controller uses the slave modport.
interface pipeline_stall_ctrl_if;
  import pipeline_stall_ctrl_pkg::*;

  logic             mem_req_i;
  logic             mem_hit_i;
  logic             mem_ack_i;
  logic             idex_memread_i;
  logic [REG_W-1:0] idex_rt_i;
  logic [REG_W-1:0] ifid_rs_i;
  logic [REG_W-1:0] ifid_rt_i;
  logic             branch_taken_i;

  logic             stall_pc_o;
  logic             stall_ifid_o;
  logic             stall_idex_o;
  logic             stall_exmem_o;
  logic             stall_memwb_o;
  logic             bubble_idex_o;
  logic             flush_ifid_o;
  logic             fill_req_o;
  logic             err_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;

  modport master (
    output mem_req_i, mem_hit_i, mem_ack_i, idex_memread_i,
           idex_rt_i, ifid_rs_i, ifid_rt_i, branch_taken_i,
    input  stall_pc_o, stall_ifid_o, stall_idex_o, stall_exmem_o, stall_memwb_o,
           bubble_idex_o, flush_ifid_o, fill_req_o, err_o, stall_cnt_o
  );

  modport slave (
    input  mem_req_i, mem_hit_i, mem_ack_i, idex_memread_i,
           idex_rt_i, ifid_rs_i, ifid_rt_i, branch_taken_i,
    output stall_pc_o, stall_ifid_o, stall_idex_o, stall_exmem_o, stall_memwb_o,
           bubble_idex_o, flush_ifid_o, fill_req_o, err_o, stall_cnt_o
  );

endinterface

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// Load-use hazard detector: a load in ID/EX whose destination feeds an IF/ID source.
// Register zero never creates a dependency.
module hazard_detect
  import pipeline_stall_ctrl_pkg::*;
(
  input  logic             memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  output logic             load_use
);

  assign load_use = memread && (idex_rt != REG_ZERO) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: data-cache miss FSM, load-use interlock and branch flush.
// Priority is miss stall, then load-use bubble, then branch flush.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
)
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  pipeline_stall_ctrl_if.slave  bus
);

  localparam logic [WAIT_CNT_W:0] TIMEOUT_LIM = (WAIT_CNT_W+1)'(TIMEOUT);

  state_t                  state;
  state_t                  state_next;
  logic                    load_use;
  logic                    miss_detect;
  logic                    miss_stall;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic [WAIT_CNT_W:0]     wait_inc;
  logic                    err;
  logic [STALL_CNT_W-1:0]  stall_cnt;
  logic                    stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;
  logic                    bubble_idex, flush_ifid;

  hazard_detect u_hazard (
    .memread  (bus.idex_memread_i),
    .idex_rt  (bus.idex_rt_i),
    .ifid_rs  (bus.ifid_rs_i),
    .ifid_rt  (bus.ifid_rt_i),
    .load_use (load_use)
  );

  assign miss_detect = (state == ST_IDLE) && bus.mem_req_i && !bus.mem_hit_i;
  assign miss_stall  = miss_detect || (state == ST_MISS) || (state == ST_REPLAY);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (miss_detect)     state_next = ST_MISS;
      ST_MISS:   if (bus.mem_ack_i)   state_next = ST_REPLAY;
      ST_REPLAY:                      state_next = ST_IDLE;
      default:                        state_next = ST_IDLE;
    endcase
  end

  // The wait counter saturates so a very long refill cannot wrap back below the limit.
  assign wait_inc = {1'b0, wait_cnt} + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else if (miss_detect) begin
      wait_cnt <= '0;
    end else if (state == ST_MISS) begin
      if (wait_cnt != '1)          wait_cnt <= wait_inc[WAIT_CNT_W-1:0];
      if (wait_inc >= TIMEOUT_LIM) err      <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                         stall_cnt <= '0;
    else if (miss_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    stall_memwb = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    if (rst_n_i) begin
      if (miss_stall) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
        stall_memwb = 1'b1;
      end else if (load_use) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end else if (bus.branch_taken_i) begin
        flush_ifid  = 1'b1;
      end
    end
  end

  assign bus.stall_pc_o    = stall_pc;
  assign bus.stall_ifid_o  = stall_ifid;
  assign bus.stall_idex_o  = stall_idex;
  assign bus.stall_exmem_o = stall_exmem;
  assign bus.stall_memwb_o = stall_memwb;
  assign bus.bubble_idex_o = bubble_idex;
  assign bus.flush_ifid_o  = flush_ifid;
  assign bus.fill_req_o    = (state == ST_MISS);
  assign bus.err_o         = err;
  assign bus.stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the stall rules.
module tb_pipeline_stall_ctrl;

  localparam int TB_TIMEOUT = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // Model state: 0 running, 1 waiting for refill, 2 replay cycle
  int   m_mode;
  int   m_miss_cycles;
  bit   m_err;
  int   m_cnt;

  pipeline_stall_ctrl_if bus ();

  pipeline_stall_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: stall pc, ifid, idex, exmem, memwb, bubble, flush, fill
  function automatic logic [7:0] dut_outs();
    return {bus.stall_pc_o, bus.stall_ifid_o, bus.stall_idex_o, bus.stall_exmem_o,
            bus.stall_memwb_o, bus.bubble_idex_o, bus.flush_ifid_o, bus.fill_req_o};
  endfunction

  function automatic logic [7:0] model_outs();
    bit miss;
    bit lu;
    logic [7:0] o;
    miss = (m_mode != 0) || (bus.mem_req_i && !bus.mem_hit_i);
    lu = bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
         ((bus.idex_rt_i == bus.ifid_rs_i) || (bus.idex_rt_i == bus.ifid_rt_i));
    o = 8'h00;
    if (!rst_n) return o;
    o[0] = (m_mode == 1);
    if (miss)                    o[7:3] = 5'b11111;
    else if (lu)                 begin o[7] = 1'b1; o[6] = 1'b1; o[2] = 1'b1; end
    else if (bus.branch_taken_i) o[1] = 1'b1;
    return o;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_miss_cycles = 0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_advance();
    bit miss;
    miss = (m_mode != 0) || (bus.mem_req_i && !bus.mem_hit_i);
    if (miss && m_cnt < 65535) m_cnt++;
    case (m_mode)
      0: if (bus.mem_req_i && !bus.mem_hit_i) begin m_mode = 1; m_miss_cycles = 0; end
      1: begin
        m_miss_cycles++;
        if (m_miss_cycles >= TB_TIMEOUT) m_err = 1'b1;
        if (bus.mem_ack_i) m_mode = 2;
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic drive(input bit req, input bit hit, input bit ack, input bit memread,
                       input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] frt,
                       input bit br);
    bus.mem_req_i      = req;
    bus.mem_hit_i      = hit;
    bus.mem_ack_i      = ack;
    bus.idex_memread_i = memread;
    bus.idex_rt_i      = rt;
    bus.ifid_rs_i      = rs;
    bus.ifid_rt_i      = frt;
    bus.branch_taken_i = br;
  endtask

  // Advance one clock from a falling edge to the next falling edge
  task automatic tick();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    drive(1, 0, 1, 1, 5'd3, 5'd3, 5'd0, 1);
    #1;
    total++;
    if (dut_outs() !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_outs: got %b want %b", dut_outs(), 8'h00);
    end
    total++;
    if (bus.stall_cnt_o !== 16'h0000 || bus.err_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_regs: cnt=%h err=%b want cnt=0000 err=0", bus.stall_cnt_o, bus.err_o);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    rst_n = 1'b1;
    #1;
    total++;
    if (dut_outs() !== model_outs()) begin
      bad++;
      $display("[TB] FAIL reset_release: got %b want %b", dut_outs(), model_outs());
    end
  endtask

  task automatic test_hit();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, (i == 2), 0, 5'd0, 5'd0, 5'd0, 0);
      #1;
      total++;
      if (dut_outs() !== 8'h00) begin
        bad++;
        $display("[TB] FAIL hit_outs[%0d]: got %b want %b", i, dut_outs(), 8'h00);
      end
      tick();
    end
    drive(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
    total++;
    if (bus.stall_cnt_o !== 16'h0000 || bus.fill_req_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hit_cnt: cnt=%h fill=%b want cnt=0000 fill=0", bus.stall_cnt_o, bus.fill_req_o);
    end
  endtask

  task automatic test_miss_ack();
    int fills;
    int stalls;
    fills = 0;
    stalls = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive((i < 5), 0, (i == 3), 0, 5'd0, 5'd0, 5'd0, 0);
      #1;
      total++;
      if (dut_outs() !== model_outs()) begin
        bad++;
        $display("[TB] FAIL miss_outs[%0d]: got %b want %b", i, dut_outs(), model_outs());
      end
      fills  += int'(bus.fill_req_o);
      stalls += int'(bus.stall_pc_o);
      tick();
    end
    total++;
    if (bus.stall_cnt_o !== 16'd5 || fills != 3 || stalls != 5) begin
      bad++;
      $display("[TB] FAIL miss_totals: cnt=%0d fills=%0d stalls=%0d want 5/3/5", bus.stall_cnt_o, fills, stalls);
    end
  endtask

  task automatic test_load_use();
    logic [4:0] rt_t  [5] = '{5'd5, 5'd0, 5'd7, 5'd7, 5'd5};
    logic [4:0] rs_t  [5] = '{5'd5, 5'd0, 5'd3, 5'd7, 5'd5};
    logic [4:0] frt_t [5] = '{5'd9, 5'd0, 5'd7, 5'd7, 5'd5};
    bit       mr_t  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bit       br_t  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bit       req_t [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] exp_t [5] = '{8'b1100_0100, 8'b0000_0010, 8'b1100_0100, 8'b0000_0000, 8'b1111_1000};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(req_t[i], 0, 0, mr_t[i], rt_t[i], rs_t[i], frt_t[i], br_t[i]);
      #1;
      total++;
      if (dut_outs() !== exp_t[i]) begin
        bad++;
        $display("[TB] FAIL load_use[%0d]: got %b want %b", i, dut_outs(), exp_t[i]);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      total++;
      if (bus.err_o !== (i >= TB_TIMEOUT) || bus.fill_req_o !== 1'b1) begin
        bad++;
        $display("[TB] FAIL timeout_err[%0d]: err=%b fill=%b want err=%b fill=1",
                 i, bus.err_o, bus.fill_req_o, (i >= TB_TIMEOUT));
      end
    end
    bus.mem_ack_i = 1'b1;
    tick();
    bus.mem_ack_i = 1'b0;
    #1;
    total++;
    if (dut_outs() !== 8'b1111_1000) begin
      bad++;
      $display("[TB] FAIL timeout_replay: got %b want %b", dut_outs(), 8'b1111_1000);
    end
    tick();
    #1;
    total++;
    if (dut_outs() !== 8'h00 || bus.err_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL timeout_idle: outs=%b err=%b want 00000000 err=1", dut_outs(), bus.err_o);
    end
  endtask

  task automatic test_reset_mid_miss();
    do_reset();
    drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
    tick();
    total++;
    if (bus.fill_req_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midmiss_fill: got %b want 1", bus.fill_req_o);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (dut_outs() !== 8'h00 || bus.stall_cnt_o !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL midmiss_async: outs=%b cnt=%h want 00000000 0000", dut_outs(), bus.stall_cnt_o);
    end
    @(negedge clk);
    drive(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (dut_outs() !== 8'h00 || bus.stall_cnt_o !== 16'h0000) begin
        bad++;
        $display("[TB] FAIL midmiss_after[%0d]: outs=%b cnt=%h want 00000000 0000", i, dut_outs(), bus.stall_cnt_o);
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1));
      #1;
      total++;
      if (dut_outs() !== model_outs()) begin
        bad++;
        $display("[TB] FAIL random_outs[%0d]: got %b want %b", i, dut_outs(), model_outs());
      end
      total++;
      if (bus.stall_cnt_o !== 16'(m_cnt) || bus.err_o !== m_err) begin
        bad++;
        $display("[TB] FAIL random_regs[%0d]: cnt=%0d err=%b want cnt=%0d err=%b",
                 i, bus.stall_cnt_o, bus.err_o, m_cnt, m_err);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 65534; i++) tick();
    total++;
    if (bus.stall_cnt_o !== 16'hFFFE) begin
      bad++;
      $display("[TB] FAIL sat_preload: got %h want FFFE", bus.stall_cnt_o);
    end
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (bus.stall_cnt_o !== 16'hFFFF) begin
      bad++;
      $display("[TB] FAIL sat_hold: got %h want FFFF", bus.stall_cnt_o);
    end
    drive(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
    bus.mem_ack_i = 1'b0;
    tick();
    total++;
    if (bus.stall_cnt_o !== 16'hFFFF || dut_outs() !== 8'h00) begin
      bad++;
      $display("[TB] FAIL sat_end: cnt=%h outs=%b want FFFF 00000000", bus.stall_cnt_o, dut_outs());
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    test_reset();
    test_hit();
    test_miss_ack();
    test_load_use();
    test_timeout();
    test_reset_mid_miss();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 SHALL expose parameter TIMEOUT, default 255, meaning the MISS-state cycle count that raises err_o.
REQ-003 SHALL expose the following ports:
- clk_i  in  1  rising-edge clock
- rst_n_i  in  1  async reset, active-low
- mem_req_i  in  1  MEM-stage instruction accesses data memory
- mem_hit_i  in  1  data cache hit, same cycle as mem_req_i
- mem_ack_i  in  1  refill complete, single-cycle pulse
- idex_memread_i  in  1  ID/EX holds a load
- idex_rt_i  in  5  load destination register
- ifid_rs_i, ifid_rt_i  in  5 each  IF/ID source registers
- branch_taken_i  in  1  branch resolved taken in ID
- stall_pc_o, stall_ifid_o, stall_idex_o, stall_exmem_o, stall_memwb_o  out  1 each  hold PC and each pipeline register
- bubble_idex_o  out  1  load ID/EX with zero control
- flush_ifid_o  out  1  zero the IF/ID instruction
- fill_req_o  out  1  refill request to memory
- err_o  out  1  sticky refill-timeout flag
- stall_cnt_o  out  16  saturating count of miss-stall cycles

Function
REQ-004 SHALL implement FSM states IDLE, MISS and REPLAY, encoded in 2 bits.
REQ-005 IDLE transitions: go to MISS when mem_req_i=1 and mem_hit_i=0; otherwise stay in IDLE.
REQ-006 MISS transitions: go to REPLAY when mem_ack_i=1; otherwise stay in MISS.
REQ-007 REPLAY transitions: always go to IDLE after one cycle.
REQ-008 miss_stall SHALL be defined as (IDLE and mem_req_i and not mem_hit_i) or MISS or REPLAY; it is combinational, so zero-cycle latency on the detecting cycle.
REQ-009 While miss_stall=1, all five stall_*_o SHALL be 1 and bubble_idex_o and flush_ifid_o SHALL be 0.
REQ-010 fill_req_o SHALL equal (state==MISS) and be glitch-free, decoded from the state register only.
REQ-011 A mem_ack_i pulse outside MISS SHALL be ignored.
REQ-012 load_use SHALL be idex_memread_i and idex_rt_i!=0 and (idex_rt_i==ifid_rs_i or idex_rt_i==ifid_rt_i).
REQ-013 When load_use=1 and miss_stall=0:
- stall_pc_o=1 and stall_ifid_o=1
- bubble_idex_o=1
- stall_idex_o, stall_exmem_o and stall_memwb_o=0
REQ-014 When branch_taken_i=1 and miss_stall=0, flush_ifid_o SHALL be 1.
REQ-015 When branch_taken_i and load_use are both 1, load_use SHALL win and flush_ifid_o SHALL be 0; the branch re-resolves next cycle.
REQ-016 Outputs SHALL follow priority miss_stall > load_use > branch flush.
REQ-017 An 8-bit wait counter SHALL clear on entering MISS and increment each MISS cycle.
REQ-018 When the wait counter reaches TIMEOUT, err_o SHALL set; it clears only on reset and the FSM keeps waiting.
REQ-019 stall_cnt_o SHALL increment by 1 on every clock edge where miss_stall=1 and SHALL saturate at 16'hFFFF without wrap.

Reset
REQ-020 Asserting rst_n_i=0 SHALL asynchronously force:
- state IDLE
- wait counter 0
- stall_cnt_o 0
- err_o 0
REQ-021 During reset, combinational outputs SHALL be forced to 0 regardless of inputs.
REQ-022 Reset asserted mid-MISS SHALL abandon the refill: fill_req_o drops immediately, and no replay occurs after release.
REQ-023 The first evaluation after rst_n_i release SHALL be on the next rising edge of clk_i.

Structure
REQ-024 The FSM state enum, the TIMEOUT default and the register-zero constant SHALL live in the shared pipeline package.
REQ-025 Hazard detection SHALL be one combinational sub-module, hazard_detect, producing load_use; the FSM and counters stay in the top module.

Verification
REQ-026 Bench SHALL cover:
- Cache hit: mem_req_i=1, mem_hit_i=1 -> all stall_*_o=0, state stays IDLE, stall_cnt_o=0.
- Miss with ack after 3 MISS cycles -> stalls high on detect cycle, 3 MISS cycles and 1 REPLAY (5 cycles total); fill_req_o high exactly 3 cycles; stall_cnt_o=5.
- Load-use: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5, branch_taken_i=1 -> stall_pc_o=stall_ifid_o=bubble_idex_o=1, flush_ifid_o=0; idex_rt_i=0 -> no stall.
- Timeout: TIMEOUT=4, no ack -> err_o=1 after 4 MISS cycles and stays 1 after a later ack; FSM reaches REPLAY then IDLE.
- Reset mid-MISS: rst_n_i=0 asynchronously -> fill_req_o=0 and all stalls 0 before the next clock edge; state IDLE after release.
- Saturation: counter preloaded to 16'hFFFE, 3 stall cycles -> stall_cnt_o=16'hFFFF.
